interboard_tx: RTL and testbench
================================

Name: interboard_tx

Overview:
- Master-side link transmitter, directly downstream of the game master FSM.
- Accepts the master's ctrl_en / ctrl_msg_type / ctrl_number message pulses into a 2-entry FIFO.
- Sends each message to the peer board over an 8-bit parallel bus using a 4-phase request/acknowledge handshake.
- Returns a one-cycle inter_ready pulse per delivered message; timeouts are retried a bounded number of times.

Parameters:
- TIMEOUT_CYC, 100000, cycles in REQ without synced ack before the attempt is abandoned.
- MAX_RETRY, 3, re-send attempts after the first timeout; total attempts = MAX_RETRY+1.
- GAP_CYC, 16, minimum cycles tx_request stays low between a timeout and the retry.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- interboard_rst  in  1  synchronous clear, active-high; same effect as rst
- ctrl_en  in  1  message strobe, one cycle
- ctrl_msg_type  in  3  message type (message_macro codes)
- ctrl_number  in  5  number payload, 0..24
- tx_ack  in  1  peer acknowledge, asynchronous to clk
- tx_request  out  1  handshake request to peer
- tx_data  out  8  {msg_type[2:0], number[4:0]}
- inter_ready  out  1  one-cycle pulse: message acknowledged and handshake closed
- busy  out  1  FIFO non-empty or FSM not in IDLE
- link_err  out  1  sticky: a message was dropped after the last retry
- overflow  out  1  sticky: ctrl_en arrived while the FIFO was full

Behaviour:
- Reset values (rst=0 or interboard_rst=1):
  - all outputs 0; FIFO empty; FSM in IDLE; counters 0.
  - Sticky flags clear only on reset.
- Reset mid-handshake: tx_request drops immediately under async reset; the in-flight message is lost and inter_ready is not pulsed.
- Synchronizer: tx_ack passes through 2 flops to give ack_s. All handshake decisions use ack_s only.
- FIFO: depth 2, write on ctrl_en, stores {type, number}.
  - Write while full: message dropped, overflow=1.
  - Same-cycle push and pop while full: the push succeeds.
- FSM states:
  - IDLE:
    - If FIFO non-empty and ack_s=0: pop, load tx_data, tx_request<=1, clear timeout/retry counters, go REQ.
    - If ack_s=1 (stale peer ack), stay in IDLE.
  - REQ:
    - ack_s=1: tx_request<=0, go WAIT_LOW.
    - Timeout counter reaches TIMEOUT_CYC-1 with ack_s still 0: tx_request<=0.
      - If retry<MAX_RETRY: retry++, go GAP.
      - Otherwise: link_err<=1, go IDLE with no inter_ready.
    - If ack_s rises on the timeout cycle, ack wins.
  - WAIT_LOW: when ack_s=0, inter_ready<=1 for exactly one cycle, go IDLE.
  - GAP: hold tx_request=0 for GAP_CYC cycles and until ack_s=0, then tx_request<=1, clear the timeout counter, go REQ. tx_data is unchanged.
- Latency:
  - ctrl_en sampled at edge E0; tx_request high after E1 when the FIFO was empty and the FSM idle.
  - Peer ack raised at edge A: tx_request falls after A+3.
  - Peer ack lowered at edge B: inter_ready high in cycle after B+3.
- tx_data is stable from tx_request rising until the FSM leaves WAIT_LOW; it changes only on a pop.
- Counters:
  - timeout counter width clog2(TIMEOUT_CYC), saturating, no wrap.
  - retry counter width clog2(MAX_RETRY+1).
- busy is combinational from FIFO count and state.

Decomposition:
- interboard_macro.v:
  - TX state encodings IB_TX_IDLE / IB_TX_REQ / IB_TX_WAIT_LOW / IB_TX_GAP.
  - Message packing field positions: type in [7:5], number in [4:0].
  - Message type codes stay in message_macro.v.
- One sub-module: sync_two_ff (2-flop synchronizer with async active-low reset, reset value 0), instantiated for tx_ack.
- FIFO stays inline (2 entries).

Test Plan:
- Single message: ctrl_en with type=SEL_NUM, number=17; peer acks after 5 cycles and drops ack 4 cycles later -> tx_data=8'b{SEL_NUM,10001} stable, one inter_ready pulse, busy returns 0.
- Back-to-back: ctrl_en on two consecutive cycles (number 3 then 9), third ctrl_en while full -> 3 then 9 delivered in order, overflow=1, third message never sent.
- Timeout/retry (TIMEOUT_CYC=20, MAX_RETRY=1, GAP_CYC=4): peer silent for the first attempt, acks the second -> request low ≥4 cycles between attempts, same tx_data, one inter_ready, link_err=0.
- Exhausted retries: peer never acks -> exactly 2 request pulses of 20 cycles, link_err=1, no inter_ready, FSM back to IDLE.
- Stale ack: tx_ack held 1 when a message is queued -> tx_request stays 0 until ack_s=0, then the handshake proceeds.
- Mid-handshake reset: rst=0 pulse while in REQ -> tx_request=0 asynchronously, FIFO empty, no inter_ready; a new message after release is sent normally.

Source files
------------

// File: rtl/interboard_tx_pkg.sv
// ----------------------------------------------------------------------------
// interboard_tx_pkg
// Shared definitions for the inter-board link transmitter:
//   - TX FSM state encodings (kept as plain 2-bit constants so older
//     Verilog code that compares state values keeps working)
//   - message packing on the 8-bit bus: type in [7:5], number in [4:0]
//   - counter width helper
// ----------------------------------------------------------------------------
package interboard_tx_pkg;

    localparam logic [1:0] IB_TX_IDLE     = 2'd0;
    localparam logic [1:0] IB_TX_REQ      = 2'd1;
    localparam logic [1:0] IB_TX_WAIT_LOW = 2'd2;
    localparam logic [1:0] IB_TX_GAP      = 2'd3;

    // Field order of the packed struct fixes the bus layout:
    // msg_type lands in [7:5], number in [4:0].
    typedef struct packed {
        logic [2:0] msg_type;
        logic [4:0] number;
    } ib_msg_t;

    // Width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/interboard_tx_if.sv
// ----------------------------------------------------------------------------
// interboard_tx_if
// Bundles the master-FSM message strobe, the peer handshake and the status
// outputs of the link transmitter.
//   master : the transmitter side (consumes ctrl_* and tx_ack, drives the rest)
//   slave  : the environment side (game master FSM + peer board)
// ----------------------------------------------------------------------------
interface interboard_tx_if;
    logic       ctrl_en;
    logic [2:0] ctrl_msg_type;
    logic [4:0] ctrl_number;
    logic       tx_ack;
    logic       tx_request;
    logic [7:0] tx_data;
    logic       inter_ready;
    logic       busy;
    logic       link_err;
    logic       overflow;

    modport master (
        input  ctrl_en, ctrl_msg_type, ctrl_number, tx_ack,
        output tx_request, tx_data, inter_ready, busy, link_err, overflow
    );

    modport slave (
        output ctrl_en, ctrl_msg_type, ctrl_number, tx_ack,
        input  tx_request, tx_data, inter_ready, busy, link_err, overflow
    );
endinterface

// File: rtl/interboard_tx_sync.sv
// ----------------------------------------------------------------------------
// sync_two_ff
// Two-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : asynchronous active-low reset, both flops clear to 0
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
// ----------------------------------------------------------------------------
module sync_two_ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;
endmodule

// File: rtl/interboard_tx.sv
// ----------------------------------------------------------------------------
// interboard_tx
// Master-side link transmitter. Queues message strobes from the game master
// FSM in a 2-entry FIFO and sends each one to the peer board over an 8-bit
// parallel bus with a 4-phase request/acknowledge handshake. A request that
// sees no acknowledge for TIMEOUT_CYC cycles is withdrawn and re-sent after a
// gap, up to MAX_RETRY times; after that the message is dropped and link_err
// is set.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   interboard_rst synchronous active-high clear, same effect as rst
//   bus.ctrl_en / ctrl_msg_type / ctrl_number   message strobe and payload
//   bus.tx_ack       peer acknowledge (asynchronous)
//   bus.tx_request   handshake request to the peer
//   bus.tx_data      {msg_type, number}
//   bus.inter_ready  one-cycle pulse per delivered message
//   bus.busy         FIFO non-empty or FSM not idle
//   bus.link_err     sticky: a message was dropped after the last retry
//   bus.overflow     sticky: a strobe arrived while the FIFO was full
// ----------------------------------------------------------------------------
module interboard_tx
    import interboard_tx_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int MAX_RETRY   = 3,
    parameter int GAP_CYC     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            interboard_rst,
    interboard_tx_if.master bus
);

    localparam int TW = cnt_width(TIMEOUT_CYC);
    localparam int RW = cnt_width(MAX_RETRY + 1);
    localparam int GW = cnt_width(GAP_CYC);

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

    // ------------------------------------------------------------------
    // Acknowledge synchronizer: every handshake decision uses ack_s only.
    // ------------------------------------------------------------------
    logic ack_s;

    sync_two_ff u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.tx_ack),
        .q   (ack_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ib_msg_t         fifo_mem [2];
    logic            wr_ptr_reg;
    logic            rd_ptr_reg;
    logic [1:0]      count_reg;

    logic [1:0]      state_reg;
    logic [TW-1:0]   tmo_cnt_reg;
    logic [RW-1:0]   retry_cnt_reg;
    logic [GW-1:0]   gap_cnt_reg;
    logic            tx_request_reg;
    logic [7:0]      tx_data_reg;
    logic            inter_ready_reg;
    logic            link_err_reg;
    logic            overflow_reg;

    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic            drop;
    logic            tmo_hit;
    logic            gap_done;

    assign fifo_full  = (count_reg == 2'd2);
    assign fifo_empty = (count_reg == 2'd0);

    // A pop happens only from IDLE and never while a stale ack is visible,
    // so the peer always sees a clean low-to-high request.
    assign pop  = (state_reg == IB_TX_IDLE) && !fifo_empty && !ack_s;
    // A full FIFO still accepts a strobe when an entry leaves in the same cycle.
    assign push = bus.ctrl_en && (!fifo_full || pop);
    assign drop = bus.ctrl_en && fifo_full && !pop;

    assign tmo_hit  = (tmo_cnt_reg == TMO_LAST);
    assign gap_done = (gap_cnt_reg == GAP_LAST);

    // FIFO storage: no reset needed, validity is tracked by count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= '{msg_type: bus.ctrl_msg_type, number: bus.ctrl_number};
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            overflow_reg <= 1'b0;
        end else if (interboard_rst) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
            if (drop) overflow_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IB_TX_IDLE;
            tmo_cnt_reg     <= '0;
            retry_cnt_reg   <= '0;
            gap_cnt_reg     <= '0;
            tx_request_reg  <= 1'b0;
            tx_data_reg     <= 8'd0;
            inter_ready_reg <= 1'b0;
            link_err_reg    <= 1'b0;
        end else if (interboard_rst) begin
            state_reg       <= IB_TX_IDLE;
            tmo_cnt_reg     <= '0;
            retry_cnt_reg   <= '0;
            gap_cnt_reg     <= '0;
            tx_request_reg  <= 1'b0;
            tx_data_reg     <= 8'd0;
            inter_ready_reg <= 1'b0;
            link_err_reg    <= 1'b0;
        end else begin
            inter_ready_reg <= 1'b0;
            case (state_reg)
                IB_TX_IDLE: begin
                    if (pop) begin
                        tx_data_reg    <= fifo_mem[rd_ptr_reg];
                        tx_request_reg <= 1'b1;
                        tmo_cnt_reg    <= '0;
                        retry_cnt_reg  <= '0;
                        state_reg      <= IB_TX_REQ;
                    end
                end

                IB_TX_REQ: begin
                    // Ack is tested first so it wins on the timeout cycle.
                    if (ack_s) begin
                        tx_request_reg <= 1'b0;
                        state_reg      <= IB_TX_WAIT_LOW;
                    end else if (tmo_hit) begin
                        tx_request_reg <= 1'b0;
                        if (retry_cnt_reg < RETRY_MAX) begin
                            retry_cnt_reg <= retry_cnt_reg + 1'b1;
                            gap_cnt_reg   <= '0;
                            state_reg     <= IB_TX_GAP;
                        end else begin
                            link_err_reg <= 1'b1;
                            state_reg    <= IB_TX_IDLE;
                        end
                    end else begin
                        // Stops at TMO_LAST, so the counter cannot wrap.
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end

                IB_TX_WAIT_LOW: begin
                    if (!ack_s) begin
                        inter_ready_reg <= 1'b1;
                        state_reg       <= IB_TX_IDLE;
                    end
                end

                IB_TX_GAP: begin
                    // Re-raise only after the full gap and with the peer's ack low.
                    if (gap_done && !ack_s) begin
                        tx_request_reg <= 1'b1;
                        tmo_cnt_reg    <= '0;
                        state_reg      <= IB_TX_REQ;
                    end else if (!gap_done) begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end

                default: state_reg <= IB_TX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.tx_request  = tx_request_reg;
    assign bus.tx_data     = tx_data_reg;
    assign bus.inter_ready = inter_ready_reg;
    assign bus.link_err    = link_err_reg;
    assign bus.overflow    = overflow_reg;
    assign bus.busy        = !fifo_empty || (state_reg != IB_TX_IDLE);

endmodule

// File: tb/tb_interboard_tx.sv
// ----------------------------------------------------------------------------
// tb_interboard_tx
// Self-checking bench for interboard_tx with short timeout/gap parameters.
// A behavioural peer answers requests with programmable delays and can
// ignore a chosen number of attempts; a monitor records request pulses and
// delivered messages. Directed vectors come from a table, corner cases from
// hand-written sequences, and a random phase is checked against a model that
// predicts deliveries from the retry budget.
// ----------------------------------------------------------------------------
module tb_interboard_tx;

    localparam int TMO   = 20;
    localparam int RETRY = 1;
    localparam int GAP   = 4;
    localparam logic [2:0] SEL_NUM = 3'd2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic interboard_rst = 1'b0;

    interboard_tx_if bus ();

    interboard_tx #(
        .TIMEOUT_CYC (TMO),
        .MAX_RETRY   (RETRY),
        .GAP_CYC     (GAP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Peer controls (written by the test, read by the environment)
    int   ack_delay    = 3;
    int   drop_delay   = 2;
    int   ignore_until = 0;
    logic peer_en      = 1'b1;
    logic force_ack    = 1'b0;

    // Monitor records (written by the environment, read by the test)
    int         rises      = 0;
    int         readies    = 0;
    int         peer_rises = 0;
    int         stab_err   = 0;
    logic [7:0] rise_data_q [$];
    logic [7:0] delivered_q [$];
    int         pulse_len_q [$];
    int         gap_len_q   [$];

    // ------------------------------------------------------------------
    // Environment: monitor + behavioural peer, evaluated on falling edges
    // ------------------------------------------------------------------
    initial begin
        logic ack_state;
        logic req_prev;
        logic ignoring;
        logic seen_fall;
        int   hi_len, lo_len, ack_cnt, drop_cnt;
        ack_state = 1'b0; req_prev = 1'b0; ignoring = 1'b0; seen_fall = 1'b0;
        hi_len = 0; lo_len = 0; ack_cnt = 0; drop_cnt = 0;
        bus.tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_request && !req_prev) begin
                rises++;
                rise_data_q.push_back(bus.tx_data);
                if (seen_fall) gap_len_q.push_back(lo_len);
                ignoring = (peer_rises < ignore_until);
                peer_rises++;
                hi_len  = 0;
                ack_cnt = 0;
            end
            if (!bus.tx_request && req_prev) begin
                pulse_len_q.push_back(hi_len);
                lo_len    = 0;
                seen_fall = 1'b1;
                drop_cnt  = 0;
            end
            if (bus.tx_request) begin
                hi_len++;
                if (bus.tx_data != rise_data_q[$]) stab_err++;
            end else begin
                lo_len++;
            end
            if (bus.inter_ready) begin
                readies++;
                delivered_q.push_back(bus.tx_data);
                $display("[%0t] delivered %02h", $time, bus.tx_data);
            end
            if (peer_en && bus.tx_request && !ignoring && !ack_state) begin
                ack_cnt++;
                if (ack_cnt >= ack_delay) ack_state = 1'b1;
            end
            if (ack_state && !bus.tx_request) begin
                drop_cnt++;
                if (drop_cnt >= drop_delay) ack_state = 1'b0;
            end
            bus.tx_ack = ack_state | force_ack;
            req_prev   = bus.tx_request;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] t, input logic [4:0] n);
        bus.ctrl_en       = 1'b1;
        bus.ctrl_msg_type = t;
        bus.ctrl_number   = n;
        step();
        bus.ctrl_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int streak;
        int n;
        streak = 0;
        n = 0;
        while (streak < 4 && n < budget) begin
            step();
            n++;
            if (!bus.busy && !bus.tx_ack) streak++;
            else streak = 0;
        end
        check({tag, "_idle_within_budget"}, (streak >= 4), 1);
    endtask

    task automatic clear_sync();
        interboard_rst = 1'b1;
        step();
        interboard_rst = 1'b0;
        step();
    endtask

    typedef struct {
        logic [2:0] t;
        logic [4:0] n;
        int         ack_d;
        int         drop_d;
        int         ignore;
        int         exp_ready;
        int         exp_pulses;
        logic       exp_link_err;
    } vec_t;

    vec_t vt [5];

    // ------------------------------------------------------------------
    // Test
    // ------------------------------------------------------------------
    initial begin
        int r0, p0, d0, pl0, s0;
        logic [7:0] exp;
        logic [7:0] msg;
        logic [7:0] exp_msgs [$];
        logic exp_link;
        int nb, k, used, ign;

        vt[0] = '{SEL_NUM, 5'd17,  5, 4, 0, 1, 1, 1'b0};
        vt[1] = '{3'd1,    5'd0,   1, 1, 0, 1, 1, 1'b0};
        vt[2] = '{3'd7,    5'd24, 12, 8, 0, 1, 1, 1'b0};
        vt[3] = '{3'd3,    5'd5,   3, 2, 1, 1, 2, 1'b0};
        vt[4] = '{3'd5,    5'd10,  3, 2, 2, 0, 2, 1'b1};

        bus.ctrl_en = 1'b0;
        bus.ctrl_msg_type = 3'd0;
        bus.ctrl_number = 5'd0;

        // Reset state
        step(); step();
        check("rst_tx_request",  bus.tx_request, 0);
        check("rst_tx_data",     bus.tx_data, 0);
        check("rst_inter_ready", bus.inter_ready, 0);
        check("rst_busy",        bus.busy, 0);
        check("rst_link_err",    bus.link_err, 0);
        check("rst_overflow",    bus.overflow, 0);
        rst = 1'b1;
        step(); step();

        // Table-driven single messages
        for (int i = 0; i < 5; i++) begin
            r0 = readies; p0 = rises; d0 = delivered_q.size(); pl0 = pulse_len_q.size(); s0 = stab_err;
            ack_delay = vt[i].ack_d;
            drop_delay = vt[i].drop_d;
            ignore_until = peer_rises + vt[i].ignore;
            send(vt[i].t, vt[i].n);
            wait_idle("vec", 300);
            exp = {vt[i].t, vt[i].n};
            $display("vector %0d: msg %02h ignore %0d readies %0d pulses %0d", i, exp, vt[i].ignore, readies - r0, rises - p0);
            check("vec_rise_data", rise_data_q[p0], exp);
            check("vec_pulses", rises - p0, vt[i].exp_pulses);
            check("vec_ready_count", readies - r0, vt[i].exp_ready);
            if (vt[i].exp_ready > 0) check("vec_delivered", delivered_q[d0], exp);
            check("vec_link_err", bus.link_err, vt[i].exp_link_err);
            check("vec_busy", bus.busy, 0);
            check("vec_data_stable", stab_err - s0, 0);
            if (vt[i].ignore > 0) begin
                check("vec_timeout_len", pulse_len_q[pl0], TMO);
                check("vec_gap_min", (gap_len_q[$] >= GAP), 1);
            end
            if (vt[i].ignore > 1) check("vec_timeout_len2", pulse_len_q[pl0 + 1], TMO);
        end

        // Synchronous clear drops the sticky link_err
        clear_sync();
        check("clr_link_err", bus.link_err, 0);
        check("clr_busy", bus.busy, 0);

        // Back-to-back strobes: 3, 9, 20 accepted, 11 arrives while full
        ack_delay = 3; drop_delay = 2; ignore_until = peer_rises;
        r0 = readies; p0 = rises; d0 = delivered_q.size();
        bus.ctrl_en = 1'b1; bus.ctrl_msg_type = 3'd1;
        bus.ctrl_number = 5'd3;  step();
        bus.ctrl_number = 5'd9;  step();
        bus.ctrl_number = 5'd20; step();
        bus.ctrl_number = 5'd11; step();
        bus.ctrl_en = 1'b0;
        wait_idle("b2b", 500);
        $display("back-to-back: readies %0d overflow %0d", readies - r0, bus.overflow);
        check("b2b_overflow", bus.overflow, 1);
        check("b2b_ready_count", readies - r0, 3);
        check("b2b_pulses", rises - p0, 3);
        check("b2b_first", delivered_q[d0], {3'd1, 5'd3});
        check("b2b_second", delivered_q[d0 + 1], {3'd1, 5'd9});
        check("b2b_third", delivered_q[d0 + 2], {3'd1, 5'd20});
        clear_sync();
        check("clr_overflow", bus.overflow, 0);

        // Stale ack: request must wait for the peer's ack to fall
        force_ack = 1'b1;
        repeat (4) step();
        r0 = readies; p0 = rises; d0 = delivered_q.size();
        send(3'd6, 5'd21);
        repeat (10) step();
        check("stale_no_request", rises - p0, 0);
        check("stale_busy", bus.busy, 1);
        force_ack = 1'b0;
        wait_idle("stale", 300);
        $display("stale ack: readies %0d", readies - r0);
        check("stale_ready_count", readies - r0, 1);
        check("stale_delivered", delivered_q[d0], {3'd6, 5'd21});

        // Request latency and asynchronous reset in REQ
        peer_en = 1'b0;
        r0 = readies;
        send(3'd2, 5'd13);
        check("lat_req_after_e0", bus.tx_request, 0);
        step();
        check("lat_req_after_e1", bus.tx_request, 1);
        repeat (3) step();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_tx_request", bus.tx_request, 0);
        check("arst_tx_data", bus.tx_data, 0);
        check("arst_busy", bus.busy, 0);
        step(); step();
        rst = 1'b1;
        step(); step();
        check("arst_no_ready", readies - r0, 0);
        peer_en = 1'b1;
        d0 = delivered_q.size();
        send(3'd4, 5'd7);
        wait_idle("arst", 300);
        $display("post-reset message: readies %0d", readies - r0);
        check("arst_ready_count", readies - r0, 1);
        check("arst_delivered", delivered_q[d0], {3'd4, 5'd7});

        // Random bursts against the retry-budget model
        clear_sync();
        exp_link = 1'b0;
        for (int b = 0; b < 25; b++) begin
            nb  = $urandom_range(1, 2);
            ign = $urandom_range(0, 2);
            ack_delay  = $urandom_range(1, 12);
            drop_delay = $urandom_range(1, 8);
            ignore_until = peer_rises + ign;
            r0 = readies; d0 = delivered_q.size(); s0 = stab_err;
            exp_msgs.delete();
            k = ign;
            bus.ctrl_en = 1'b1;
            for (int i = 0; i < nb; i++) begin
                msg = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 24))};
                bus.ctrl_msg_type = msg[7:5];
                bus.ctrl_number   = msg[4:0];
                used = (k > RETRY + 1) ? RETRY + 1 : k;
                k -= used;
                if (used <= RETRY) exp_msgs.push_back(msg);
                else exp_link = 1'b1;
                step();
            end
            bus.ctrl_en = 1'b0;
            wait_idle("rnd", 600);
            $display("burst %0d: %0d msgs ignore %0d readies %0d expected %0d", b, nb, ign, readies - r0, exp_msgs.size());
            check("rnd_ready_count", readies - r0, exp_msgs.size());
            for (int i = 0; i < exp_msgs.size(); i++)
                check("rnd_delivered", delivered_q[d0 + i], exp_msgs[i]);
            check("rnd_link_err", bus.link_err, exp_link);
            check("rnd_overflow", bus.overflow, 0);
            check("rnd_data_stable", stab_err - s0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
